msx_reload_seq: RTL and testbench
=================================

# msx_reload_seq

Sequencer that responds to the cartridge-configuration reload pulse produced by the MSX configuration decoder. On each reload, and once after power-on, it:
- holds the MSX core in reset;
- flushes the mapper state of every slot whose cartridge type changed;
- waits, bounded by a timeout, for ROM images required by ROM-type slots;
- publishes the cartridge types the slot mappers act on.

It sits between the configuration decoder and the slot/mapper logic in the MSX top level.

## Interface
Parameters:
- RESET_HOLD, 1024: cycles the core reset is held after the flush cycle (must be ≥ 1).
- ROM_TIMEOUT, 10_000_000: cycles to wait for required ROM images (must be ≥ 1; 24-bit counter).

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  reset, asynchronous, active-low.
- reload  in  1  one-cycle pulse: cartridge configuration changed.
- user_reset  in  1  user reset button, level; its rising edge acts like reload.
- typ_a  in  3  requested slot A cartridge type (0 = ROM, 7 = EMPTY).
- typ_b  in  3  requested slot B cartridge type (0 = ROM, 7 = EMPTY).
- rom_a_loaded  in  1  level: slot A ROM image present.
- rom_b_loaded  in  1  level: slot B ROM image present.
- msx_reset  out  1  active-high reset to the MSX core.
- busy  out  1  sequence in progress.
- slot_flush  out  2  one-cycle pulse per slot ([0] = A, [1] = B); clear mapper/SRAM-bank state.
- typ_a_act  out  3  type applied to the slot A mapper.
- typ_b_act  out  3  type applied to the slot B mapper.
- rom_timeout  out  1  sticky: the last sequence hit the ROM timeout.

## Operation
States: IDLE, FLUSH, HOLD, WAIT_ROM, RELEASE, plus the internal power-on entry POR.

Reset values (asynchronous, while reset_n = 0):
- state = POR.
- msx_reset = 1, busy = 1.
- slot_flush = 0.
- typ_a_act = typ_b_act = 7.
- rom_timeout = 0.
- Counter = 0.
- user_reset edge register = 0.

Trigger = reload, or a user_reset rising edge (0→1 against a registered copy), or the first clock edge in POR.

On trigger, from any state including mid-sequence (restart, not queue):
- Compute changed[0] = (typ_a ≠ typ_a_act) and changed[1] = (typ_b ≠ typ_b_act).
- Load typ_a_act ← typ_a and typ_b_act ← typ_b.
- Clear rom_timeout.
- Go to FLUSH.

FLUSH (1 cycle):
- slot_flush = the changed mask captured at the trigger.
- Load counter ← RESET_HOLD − 1; go to HOLD.

HOLD:
- Decrement the counter.
- When the counter = 0, define need[x] = (typ_x_act = 0) and ¬rom_x_loaded.
- If need ≠ 0: load counter ← ROM_TIMEOUT − 1 and go to WAIT_ROM. Otherwise go to RELEASE.

WAIT_ROM:
- If need = 0 (re-evaluated every cycle from the live loaded inputs), go to RELEASE.
- Else, if counter = 0: set rom_timeout; force every slot with need[x] = 1 to typ_x_act ← 7; go to RELEASE.
- Else decrement the counter.

RELEASE (1 cycle): go to IDLE.

IDLE: wait for a trigger.

Output rules:
- msx_reset = busy = 1 in every state except IDLE; both are registered.
- A trigger and a ROM becoming loaded in the same cycle: the trigger wins.
- A reload and a user_reset edge in the same cycle count as one trigger.
- typ_x_act changes only at the trigger cycle or at timeout.
- The mappers must treat typ_x_act = 7 as an empty slot.

## Timing
- Trigger at edge N: typ_x_act is updated and FLUSH is entered at N+1; slot_flush is high during the cycle after N+1 (FLUSH).
- Reset pulse length without ROM wait: 1 (FLUSH) + RESET_HOLD (HOLD) + 1 (RELEASE) cycles. msx_reset falls on the edge that enters IDLE.
- ROM wait adds between 1 and ROM_TIMEOUT cycles.
- Once the input becomes 1, the rom_x_loaded → release latency is 1 cycle from WAIT_ROM to RELEASE.
- After reset_n deasserts, the first clock edge leaves POR with changed = mask of slots whose requested type ≠ 7.
- reset_n assertion mid-sequence returns everything immediately to the reset values.

## Test plan
- Power-on, RESET_HOLD = 4, typ_a = 1, typ_b = 7 → slot_flush = 01 for one cycle; msx_reset high for 6 cycles after POR exit; typ_a_act = 1, typ_b_act = 7.
- Idle with typ_a = 1; reload with typ_a = 1, typ_b = 3 → slot_flush = 10; typ_b_act = 3; msx_reset high for exactly RESET_HOLD + 2 cycles.
- Reload with typ_a = 0, rom_a_loaded = 0; raise rom_a_loaded 20 cycles into WAIT_ROM → release 1 cycle later; rom_timeout = 0; typ_a_act = 0.
- ROM_TIMEOUT = 8, typ_b = 0, rom_b_loaded never set → after 8 cycles in WAIT_ROM: rom_timeout = 1, typ_b_act = 7, msx_reset falls 1 cycle later.
- Second reload during HOLD with a different typ_a → the sequence restarts at FLUSH; the changed mask is relative to the already-updated typ_a_act; the full RESET_HOLD is served again.
- user_reset held high for 100 cycles with types unchanged → exactly one sequence, slot_flush = 00; reset_n pulsed low mid-WAIT_ROM → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/msx_reload_seq.sv
// ============================================================================
// Module   : msx_reload_seq
// Brief    : Cartridge reload sequencer: holds the MSX core in reset, flushes
//            changed slots, waits (bounded) for ROM images, publishes types.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module msx_reload_seq #(
    parameter int RESET_HOLD  = 1024,
    parameter int ROM_TIMEOUT = 10_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       reload,
    input  logic       user_reset,
    input  logic [2:0] typ_a,
    input  logic [2:0] typ_b,
    input  logic       rom_a_loaded,
    input  logic       rom_b_loaded,
    output logic       msx_reset,
    output logic       busy,
    output logic [1:0] slot_flush,
    output logic [2:0] typ_a_act,
    output logic [2:0] typ_b_act,
    output logic       rom_timeout
);

    localparam int CW = 24;

    localparam logic [2:0] c_POR      = 3'd0;
    localparam logic [2:0] c_IDLE     = 3'd1;
    localparam logic [2:0] c_FLUSH    = 3'd2;
    localparam logic [2:0] c_HOLD     = 3'd3;
    localparam logic [2:0] c_WAIT_ROM = 3'd4;
    localparam logic [2:0] c_RELEASE  = 3'd5;

    localparam logic [2:0] c_TYP_ROM   = 3'd0;
    localparam logic [2:0] c_TYP_EMPTY = 3'd7;

    localparam logic [CW-1:0] c_HOLD_LOAD = CW'(RESET_HOLD - 1);
    localparam logic [CW-1:0] c_ROM_LOAD  = CW'(ROM_TIMEOUT - 1);

    logic [2:0]    r_state;
    logic          r_busy;
    logic [1:0]    r_flush;
    logic [2:0]    r_typ_a;
    logic [2:0]    r_typ_b;
    logic          r_timeout;
    logic [CW-1:0] r_cnt;
    logic          r_user_q;

    logic          w_trigger;
    logic [1:0]    w_changed;
    logic [1:0]    w_need;

    // POR behaves as a trigger on its first edge, so power-up reuses the reload path
    assign w_trigger = reload | (user_reset & ~r_user_q) | (r_state == c_POR);
    assign w_changed = {typ_b != r_typ_b, typ_a != r_typ_a};
    assign w_need    = {(r_typ_b == c_TYP_ROM) & ~rom_b_loaded,
                        (r_typ_a == c_TYP_ROM) & ~rom_a_loaded};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_POR;
            r_busy    <= 1'b1;
            r_flush   <= 2'b00;
            r_typ_a   <= c_TYP_EMPTY;
            r_typ_b   <= c_TYP_EMPTY;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
            r_user_q  <= 1'b0;
        end else begin
            r_user_q <= user_reset;
            r_flush  <= 2'b00;
            if (w_trigger) begin
                // Restart from any state; mask is relative to the types currently applied
                r_flush   <= w_changed;
                r_typ_a   <= typ_a;
                r_typ_b   <= typ_b;
                r_timeout <= 1'b0;
                r_busy    <= 1'b1;
                r_state   <= c_FLUSH;
            end else begin
                case (r_state)
                    c_FLUSH: begin
                        r_cnt   <= c_HOLD_LOAD;
                        r_state <= c_HOLD;
                    end
                    c_HOLD: begin
                        if (r_cnt == '0) begin
                            if (w_need != 2'b00) begin
                                r_cnt   <= c_ROM_LOAD;
                                r_state <= c_WAIT_ROM;
                            end else begin
                                r_state <= c_RELEASE;
                            end
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    c_WAIT_ROM: begin
                        if (w_need == 2'b00) begin
                            r_state <= c_RELEASE;
                        end else if (r_cnt == '0) begin
                            // Slots whose image never arrived are demoted to empty
                            r_timeout <= 1'b1;
                            if (w_need[0]) r_typ_a <= c_TYP_EMPTY;
                            if (w_need[1]) r_typ_b <= c_TYP_EMPTY;
                            r_state   <= c_RELEASE;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    c_RELEASE: begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                    c_IDLE: begin
                        r_state <= c_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b1;
                        r_state <= c_POR;
                    end
                endcase
            end
        end
    end

    assign msx_reset   = r_busy;
    assign busy        = r_busy;
    assign slot_flush  = r_flush;
    assign typ_a_act   = r_typ_a;
    assign typ_b_act   = r_typ_b;
    assign rom_timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_msx_reload_seq.sv
// ============================================================================
// Module   : tb_msx_reload_seq
// Brief    : Self-checking bench for msx_reload_seq (vector table + sequences).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_msx_reload_seq;

    localparam int RESET_HOLD  = 4;
    localparam int ROM_TIMEOUT = 24;

    logic       clk;
    logic       reset_n;
    logic       reload;
    logic       user_reset;
    logic [2:0] typ_a;
    logic [2:0] typ_b;
    logic       rom_a_loaded;
    logic       rom_b_loaded;
    logic       msx_reset;
    logic       busy;
    logic [1:0] slot_flush;
    logic [2:0] typ_a_act;
    logic [2:0] typ_b_act;
    logic       rom_timeout;

    int n_vec;
    int n_err;

    // {msx_reset, busy, slot_flush, typ_a_act, typ_b_act, rom_timeout}
    typedef struct packed {
        logic        rl;
        logic        ur;
        logic [2:0]  ta;
        logic [2:0]  tb;
        logic        ra;
        logic        rb;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    msx_reload_seq #(
        .RESET_HOLD  (RESET_HOLD),
        .ROM_TIMEOUT (ROM_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .reload       (reload),
        .user_reset   (user_reset),
        .typ_a        (typ_a),
        .typ_b        (typ_b),
        .rom_a_loaded (rom_a_loaded),
        .rom_b_loaded (rom_b_loaded),
        .msx_reset    (msx_reset),
        .busy         (busy),
        .slot_flush   (slot_flush),
        .typ_a_act    (typ_a_act),
        .typ_b_act    (typ_b_act),
        .rom_timeout  (rom_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] pk(input logic m, input logic b, input logic [1:0] f,
                                       input logic [2:0] a, input logic [2:0] t, input logic to);
        return {m, b, f, a, t, to};
    endfunction

    function automatic vec_t mk(input logic rl, input logic ur, input logic [2:0] ta,
                                input logic [2:0] tb, input logic ra, input logic rb,
                                input logic [10:0] exp);
        return {rl, ur, ta, tb, ra, rb, exp};
    endfunction

    function automatic logic [10:0] outs();
        return {msx_reset, busy, slot_flush, typ_a_act, typ_b_act, rom_timeout};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b (msx,busy,flush,ta,tb,to)", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int busy_cycles;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n      = 1'b0;
        reload       = 1'b0;
        user_reset   = 1'b0;
        typ_a        = 3'd1;
        typ_b        = 3'd7;
        rom_a_loaded = 1'b0;
        rom_b_loaded = 1'b0;

        // Power-on: POR exit flushes slot A only, 6 cycles of core reset
        vecs.push_back(mk(0, 0, 1, 7, 0, 0, pk(1, 1, 2'b01, 1, 7, 0)));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 7, 0, 0, pk(1, 1, 2'b00, 1, 7, 0)));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 0, 1, 7, 0, 0, pk(0, 0, 2'b00, 1, 7, 0)));
        // Reload changing slot B only: RESET_HOLD+2 cycles of reset
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, pk(1, 1, 2'b10, 1, 3, 0)));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 3, 0, 0, pk(1, 1, 2'b00, 1, 3, 0)));
        vecs.push_back(mk(0, 0, 1, 3, 0, 0, pk(0, 0, 2'b00, 1, 3, 0)));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs(), pk(1, 1, 2'b00, 7, 7, 0));
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            reload       = vecs[i].rl;
            user_reset   = vecs[i].ur;
            typ_a        = vecs[i].ta;
            typ_b        = vecs[i].tb;
            rom_a_loaded = vecs[i].ra;
            rom_b_loaded = vecs[i].rb;
            tick();
            check($sformatf("table[%0d]", i), outs(), vecs[i].exp);
        end

        // ROM wait on slot A, image arrives 20 cycles into WAIT_ROM
        typ_a = 3'd0; reload = 1'b1;
        tick();
        reload = 1'b0;
        check("rom_wait_flush", outs(), pk(1, 1, 2'b01, 0, 3, 0));
        repeat (5) tick();
        repeat (19) tick();
        check("rom_wait_busy", outs(), pk(1, 1, 2'b00, 0, 3, 0));
        rom_a_loaded = 1'b1;
        tick();
        check("rom_wait_release", outs(), pk(1, 1, 2'b00, 0, 3, 0));
        tick();
        check("rom_wait_idle", outs(), pk(0, 0, 2'b00, 0, 3, 0));

        // Slot B ROM never arrives: timeout after ROM_TIMEOUT cycles
        typ_b = 3'd0; reload = 1'b1;
        tick();
        reload = 1'b0;
        check("to_flush", outs(), pk(1, 1, 2'b10, 0, 0, 0));
        repeat (5) tick();
        repeat (ROM_TIMEOUT - 1) tick();
        check("to_before", outs(), pk(1, 1, 2'b00, 0, 0, 0));
        tick();
        check("to_hit", outs(), pk(1, 1, 2'b00, 0, 7, 1));
        tick();
        check("to_idle", outs(), pk(0, 0, 2'b00, 0, 7, 1));

        // Restart during HOLD: mask relative to already-updated act, full hold again
        typ_a = 3'd2; typ_b = 3'd7; reload = 1'b1;
        tick();
        reload = 1'b0;
        check("rs_flush1", outs(), pk(1, 1, 2'b01, 2, 7, 0));
        repeat (2) tick();
        typ_a = 3'd5; reload = 1'b1;
        tick();
        reload = 1'b0;
        check("rs_flush2", outs(), pk(1, 1, 2'b01, 5, 7, 0));
        repeat (5) tick();
        check("rs_hold_full", outs(), pk(1, 1, 2'b00, 5, 7, 0));
        tick();
        check("rs_idle", outs(), pk(0, 0, 2'b00, 5, 7, 0));

        // user_reset held: exactly one sequence with empty flush mask
        user_reset = 1'b1;
        tick();
        check("ur_flush", outs(), pk(1, 1, 2'b00, 5, 7, 0));
        busy_cycles = 1;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (busy) busy_cycles++;
        end
        check1("ur_one_seq", busy_cycles == RESET_HOLD + 2, 1'b1);
        check("ur_end", outs(), pk(0, 0, 2'b00, 5, 7, 0));
        user_reset = 1'b0;
        tick();

        // Async reset mid WAIT_ROM, then POR re-entry
        typ_a = 3'd0; rom_a_loaded = 1'b0; reload = 1'b1;
        tick();
        reload = 1'b0;
        repeat (8) tick();
        check1("ar_in_wait", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_async", outs(), pk(1, 1, 2'b00, 7, 7, 0));
        rom_a_loaded = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        check("ar_por_exit", outs(), pk(1, 1, 2'b01, 0, 7, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
